ysyx_23060221_icache: RTL and testbench

Direct-mapped, read-only instruction cache between the IFU's AXI read master and the memory-side AXI bus (crossbar/arbiter). Accepts single-word fetch requests from the IFU, answers hits from local storage, and refills missing lines with one INCR burst. Transparent to the IFU: same AR/R handshake it already drives, only latency changes.

---
 rtl/ysyx_23060221_icache_pkg.sv | 36 +++
 rtl/ysyx_23060221_icache_array.sv | 63 ++++++
 rtl/ysyx_23060221_icache.sv | 227 ++++++++++++++++++++++
 tb/tb_ysyx_23060221_icache.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060221_icache_pkg.sv
// ysyx_23060221_icache_pkg
// Shared definitions for the instruction cache: controller state encoding,
// AXI field constants and helpers that derive address-field widths from the
// cache geometry (SETS lines of LINE_WORDS 32-bit words).
package ysyx_23060221_icache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_AR,
        MISS_R,
        RESP
    } state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam int         ADDR_W      = 32;

    // Word-offset field width inside a line.
    function automatic int ofs_w(input int line_words);
        return $clog2(line_words);
    endfunction

    // Line-index field width.
    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    // Tag width: everything above index, offset and the byte bits [1:0].
    function automatic int tag_w(input int sets, input int line_words);
        return ADDR_W - 2 - ofs_w(line_words) - idx_w(sets);
    endfunction

endpackage

// File: rtl/ysyx_23060221_icache_array.sv
// ysyx_23060221_icache_array
// Tag/valid/data storage for the direct-mapped instruction cache.
// Ports:
//   clk, rst (async, active-low; clears valid bits only)
//   inv                       : clear every valid bit at the next edge
//   rd_index, rd_offset       : combinational read port -> rd_word, rd_tag, rd_valid
//   wr_en, wr_index, wr_offset, wr_word : one-word data write port
//   tag_we, wr_tag            : write the tag of wr_index and mark the line valid
module ysyx_23060221_icache_array
    import ysyx_23060221_icache_pkg::*;
#(
    parameter int  SETS       = 16,
    parameter int  LINE_WORDS = 4,
    localparam int OFS_W      = ofs_w(LINE_WORDS),
    localparam int IDX_W      = idx_w(SETS),
    localparam int TAG_W      = tag_w(SETS, LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inv,
    input  logic [IDX_W-1:0] rd_index,
    input  logic [OFS_W-1:0] rd_offset,
    output logic [31:0]      rd_word,
    output logic [TAG_W-1:0] rd_tag,
    output logic             rd_valid,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [OFS_W-1:0] wr_offset,
    input  logic [31:0]      wr_word,
    input  logic             tag_we,
    input  logic [TAG_W-1:0] wr_tag
);

    logic [31:0]      data_mem [SETS*LINE_WORDS];
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [SETS-1:0]  valid;

    assign rd_word  = data_mem[{rd_index, rd_offset}];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_valid = valid[rd_index];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[{wr_index, wr_offset}] <= wr_word;
        end
        if (tag_we) begin
            tag_mem[wr_index] <= wr_tag;
        end
    end

    // Invalidate wins over a same-cycle validate so a fence never leaves
    // a freshly written line visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (inv) begin
            valid <= '0;
        end else if (tag_we) begin
            valid[wr_index] <= 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_23060221_icache.sv
// ysyx_23060221_icache
// Direct-mapped read-only instruction cache between the IFU AXI read master
// (s_* ports) and the memory-side AXI bus (m_* ports). Hits are answered from
// local storage two cycles after the request handshake; misses refill the whole
// line with one INCR burst and answer one cycle after the last beat.
// Ports:
//   clk, rst (async, active-low), fence_i (invalidate all lines)
//   s_ar*/s_r* : IFU-side single-word read channel (rlast=1, rid=0)
//   m_ar*/m_r* : refill read channel (line-aligned INCR burst of LINE_WORDS beats)
// Optional build macro ICACHE_PERF_EN: adds hit/miss counters updated per lookup.
module ysyx_23060221_icache
    import ysyx_23060221_icache_pkg::*;
#(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fence_i,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rlast,
    output logic [3:0]  s_rid,
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [31:0] m_araddr,
    output logic [3:0]  m_arid,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast
);

    localparam int OFS_W = ofs_w(LINE_WORDS);
    localparam int IDX_W = idx_w(SETS);
    localparam int TAG_W = tag_w(SETS, LINE_WORDS);

    state_t state, state_next;

    logic [31:0]      req_addr;
    logic [OFS_W-1:0] req_ofs;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [OFS_W-1:0] beat_cnt;
    logic             err;
    logic             poison;
    logic [31:0]      rdata_q;
    logic [1:0]       rresp_q;

    logic [31:0]      rd_word;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_valid;
    logic             hit;
    logic             beat_fire;
    logic             beat_err;
    logic             last_fire;
    logic             line_ok;

    assign req_ofs = req_addr[OFS_W+1:2];
    assign req_idx = req_addr[OFS_W+2 +: IDX_W];
    assign req_tag = req_addr[31 -: TAG_W];

    assign hit       = rd_valid && (rd_tag == req_tag);
    assign beat_fire = (state == MISS_R) && m_rvalid;
    assign beat_err  = (m_rresp != RESP_OKAY);
    assign last_fire = beat_fire && m_rlast;
    // A fence on the closing beat itself must also keep the line invalid.
    assign line_ok   = !err && !beat_err && !poison && !fence_i;

    ysyx_23060221_icache_array #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .inv       (fence_i),
        .rd_index  (req_idx),
        .rd_offset (req_ofs),
        .rd_word   (rd_word),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .wr_en     (beat_fire),
        .wr_index  (req_idx),
        .wr_offset (beat_cnt),
        .wr_word   (m_rdata),
        .tag_we    (last_fire && line_ok),
        .wr_tag    (req_tag)
    );

    // Constant / derived outputs
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;
    assign s_rlast   = s_rvalid;
    assign s_rid     = 4'd0;
    assign m_araddr  = {req_tag, req_idx, {(OFS_W+2){1'b0}}};
    assign m_arid    = 4'd0;
    assign m_arlen   = 8'(LINE_WORDS - 1);
    assign m_arsize  = SIZE_4B;
    assign m_arburst = BURST_INCR;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        s_arready  = 1'b0;
        s_rvalid   = 1'b0;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        case (state)
            IDLE: begin
                // Held low while reset is asserted even though state is IDLE.
                s_arready = rst;
                if (s_arvalid) begin
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                state_next = hit ? RESP : MISS_AR;
            end
            MISS_AR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_next = MISS_R;
                end
            end
            MISS_R: begin
                m_rready = 1'b1;
                if (m_rvalid && m_rlast) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                s_rvalid = 1'b1;
                if (s_rready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request address is only meaningful after a handshake, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && s_arvalid) begin
            req_addr <= s_araddr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt <= '0;
            err      <= 1'b0;
            poison   <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    err      <= 1'b0;
                    poison   <= 1'b0;
                end
                LOOKUP: begin
                    if (hit) begin
                        rdata_q <= rd_word;
                        rresp_q <= RESP_OKAY;
                    end
                end
                MISS_R: begin
                    if (m_rvalid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == req_ofs) begin
                            rdata_q <= m_rdata;
                        end
                        if (beat_err) begin
                            err <= 1'b1;
                        end
                        if (m_rlast) begin
                            rresp_q <= (err || beat_err) ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                default: ;
            endcase
            // The refill still runs to completion; poison only blocks validation.
            if (fence_i && (state == MISS_AR || state == MISS_R)) begin
                poison <= 1'b1;
            end
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == LOOKUP) begin
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end else begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_23060221_icache.sv
// tb_ysyx_23060221_icache
// Directed bench for the instruction cache at SETS=16, LINE_WORDS=4
// (offset = addr[3:2], index = addr[7:4], tag = addr[31:8]).
// The bench plays the memory: word at address a is {a[31:2],2'b00} ^ 32'h5A5A_1234,
// e.g. 0x8000_0004 -> 0xDA5A_1230, 0x8000_0008 -> 0xDA5A_123C.
module tb_ysyx_23060221_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        fence_i;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_araddr;
    logic        s_rvalid;
    logic        s_rready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic [3:0]  s_rid;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_araddr;
    logic [3:0]  m_arid;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_rvalid;
    logic        m_rready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    ysyx_23060221_icache dut (
        .clk       (clk),
        .rst       (rst),
        .fence_i   (fence_i),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_araddr  (s_araddr),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .s_rid     (s_rid),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_araddr  (m_araddr),
        .m_arid    (m_arid),
        .m_arlen   (m_arlen),
        .m_arsize  (m_arsize),
        .m_arburst (m_arburst),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rlast   (m_rlast)
    );

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A5A_1234;
    endfunction

    // One complete IFU fetch. Serves the refill burst when the DUT asks for one,
    // optionally with an error beat, a fence pulse on a beat, a fence pulse in
    // LOOKUP, and `hold` cycles of s_rready back-pressure.
    task automatic run_fetch(input logic [31:0] addr, input bit exp_miss,
                             input int err_beat, input int fence_beat,
                             input bit fence_lookup, input int hold,
                             input string name);
        int          k;
        int          seen;
        bit          hs;
        logic [31:0] base;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        base     = addr & 32'hFFFF_FFF0;
        exp_data = memword(addr);
        exp_resp = (exp_miss && err_beat >= 0) ? 2'b10 : 2'b00;

        @(negedge clk);
        s_arvalid = 1'b1;
        s_araddr  = addr;
        hs = 1'b0;
        for (int i = 0; i < 10 && !hs; i++) begin
            if (s_arready === 1'b1) hs = 1'b1;
            else @(negedge clk);
        end
        tests++;
        if (!hs) begin
            failed++;
            $display("FAIL %s handshake: s_arready never high", name);
            s_arvalid = 1'b0;
            return;
        end

        k = 0;
        seen = 0;
        while (seen == 0 && k < 20) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                s_arvalid = 1'b0;
                fence_i   = fence_lookup;
                tests++;
                if (s_arready !== 1'b0) begin
                    failed++;
                    $display("FAIL %s arready_lookup: got %b want 0", name, s_arready);
                end
            end else begin
                fence_i = 1'b0;
            end
            if (m_arvalid === 1'b1) seen = 1;
            else if (s_rvalid === 1'b1) seen = 2;
        end
        fence_i = 1'b0;
        tests++;
        if (seen == 0) begin
            failed++;
            $display("FAIL %s timeout: no m_arvalid or s_rvalid", name);
            return;
        end
        tests++;
        if ((seen == 1) != exp_miss) begin
            failed++;
            $display("FAIL %s hit_or_miss: got miss=%0d want miss=%0d", name, seen == 1, exp_miss);
        end
        tests++;
        if (k != 2) begin
            failed++;
            $display("FAIL %s latency: got %0d cycles want 2", name, k);
        end

        if (seen == 1) begin
            tests++;
            if (m_araddr !== base || m_arlen !== 8'd3 || m_arsize !== 3'b010 ||
                m_arburst !== 2'b01 || m_arid !== 4'd0) begin
                failed++;
                $display("FAIL %s ar_fields: got addr=%h len=%0d size=%b burst=%b id=%0d want addr=%h len=3 size=010 burst=01 id=0",
                         name, m_araddr, m_arlen, m_arsize, m_arburst, m_arid, base);
            end
            @(negedge clk);
            tests++;
            if (m_arvalid !== 1'b1 || m_araddr !== base) begin
                failed++;
                $display("FAIL %s ar_stable: got valid=%b addr=%h want 1 %h", name, m_arvalid, m_araddr, base);
            end
            m_arready = 1'b1;
            @(negedge clk);
            m_arready = 1'b0;
            tests++;
            if (m_arvalid !== 1'b0) begin
                failed++;
                $display("FAIL %s ar_drop: got m_arvalid=%b want 0", name, m_arvalid);
            end
            for (int b = 0; b < 4; b++) begin
                m_rvalid = 1'b1;
                m_rdata  = memword(base + 32'(4 * b));
                m_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
                m_rlast  = (b == 3);
                fence_i  = (b == fence_beat);
                tests++;
                if (m_rready !== 1'b1 || s_rvalid !== 1'b0) begin
                    failed++;
                    $display("FAIL %s beat%0d: got rready=%b s_rvalid=%b want 1 0", name, b, m_rready, s_rvalid);
                end
                @(negedge clk);
            end
            m_rvalid = 1'b0;
            m_rlast  = 1'b0;
            m_rresp  = 2'b00;
            fence_i  = 1'b0;
            tests++;
            if (s_rvalid !== 1'b1) begin
                failed++;
                $display("FAIL %s rvalid_after_last: got %b want 1", name, s_rvalid);
            end
        end

        tests++;
        if (s_rdata !== exp_data || s_rresp !== exp_resp || s_rlast !== 1'b1 || s_rid !== 4'd0) begin
            failed++;
            $display("FAIL %s response: got data=%h resp=%b last=%b id=%0d want data=%h resp=%b last=1 id=0",
                     name, s_rdata, s_rresp, s_rlast, s_rid, exp_data, exp_resp);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            tests++;
            if (s_rvalid !== 1'b1 || s_rdata !== exp_data || s_arready !== 1'b0) begin
                failed++;
                $display("FAIL %s hold%0d: got rvalid=%b data=%h arready=%b want 1 %h 0",
                         name, i, s_rvalid, s_rdata, s_arready, exp_data);
            end
        end
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
        tests++;
        if (s_rvalid !== 1'b0 || s_arready !== 1'b1) begin
            failed++;
            $display("FAIL %s back_to_idle: got rvalid=%b arready=%b want 0 1", name, s_rvalid, s_arready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (s_arready !== 1'b0 || s_rvalid !== 1'b0 || m_arvalid !== 1'b0 || m_rready !== 1'b0 ||
            s_rdata !== 32'd0 || s_rresp !== 2'b00) begin
            failed++;
            $display("FAIL reset_values: got arready=%b rvalid=%b m_arvalid=%b m_rready=%b rdata=%h rresp=%b want all 0",
                     s_arready, s_rvalid, m_arvalid, m_rready, s_rdata, s_rresp);
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (s_arready !== 1'b1) begin
            failed++;
            $display("FAIL reset_release_arready: got %b want 1", s_arready);
        end
    endtask

    task automatic test_cold_miss();
        run_fetch(32'h8000_0004, 1'b1, -1, -1, 1'b0, 0, "cold_miss");
    endtask

    task automatic test_hit();
        run_fetch(32'h8000_0008, 1'b0, -1, -1, 1'b0, 0, "hit");
    endtask

    task automatic test_conflict();
        run_fetch(32'h8000_0100, 1'b1, -1, -1, 1'b0, 0, "conflict_new_tag");
        run_fetch(32'h8000_0000, 1'b1, -1, -1, 1'b0, 0, "conflict_old_tag");
        run_fetch(32'h8000_000C, 1'b0, -1, -1, 1'b0, 0, "conflict_rehit");
    endtask

    task automatic test_error();
        run_fetch(32'h8000_0040, 1'b1, 2, -1, 1'b0, 0, "err_refill");
        run_fetch(32'h8000_0040, 1'b1, -1, -1, 1'b0, 0, "err_refetch");
        run_fetch(32'h8000_0044, 1'b0, -1, -1, 1'b0, 0, "err_then_hit");
    endtask

    task automatic test_fence_refill();
        run_fetch(32'h8000_0080, 1'b1, -1, 1, 1'b0, 0, "fence_in_refill");
        run_fetch(32'h8000_0084, 1'b1, -1, -1, 1'b0, 0, "fence_refill_remiss");
        run_fetch(32'h8000_0088, 1'b0, -1, -1, 1'b0, 0, "fence_refill_hit");
    endtask

    task automatic test_fence_idle();
        @(negedge clk);
        fence_i = 1'b1;
        @(negedge clk);
        fence_i = 1'b0;
        run_fetch(32'h8000_008C, 1'b1, -1, -1, 1'b0, 0, "fence_idle_miss");
    endtask

    task automatic test_fence_hit();
        run_fetch(32'h8000_0080, 1'b0, -1, -1, 1'b1, 0, "fence_with_hit");
        run_fetch(32'h8000_0080, 1'b1, -1, -1, 1'b0, 0, "fence_with_hit_after");
    endtask

    task automatic test_back_to_back();
        run_fetch(32'h8000_0084, 1'b0, -1, -1, 1'b0, 5, "backpressure");
        run_fetch(32'h8000_0088, 1'b0, -1, -1, 1'b0, 0, "back_to_back");
    endtask

    task automatic test_reset_mid_refill();
        @(negedge clk);
        s_arvalid = 1'b1;
        s_araddr  = 32'h8000_00C4;
        @(negedge clk);
        s_arvalid = 1'b0;
        @(negedge clk);
        tests++;
        if (m_arvalid !== 1'b1) begin
            failed++;
            $display("FAIL rst_mid_ar: got m_arvalid=%b want 1", m_arvalid);
        end
        m_arready = 1'b1;
        @(negedge clk);
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        m_rdata   = memword(32'h8000_00C0);
        m_rresp   = 2'b00;
        m_rlast   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (s_arready !== 1'b0 || s_rvalid !== 1'b0 || m_arvalid !== 1'b0 || m_rready !== 1'b0 ||
            s_rdata !== 32'd0 || s_rresp !== 2'b00) begin
            failed++;
            $display("FAIL rst_mid_values: got arready=%b rvalid=%b m_arvalid=%b m_rready=%b rdata=%h rresp=%b want all 0",
                     s_arready, s_rvalid, m_arvalid, m_rready, s_rdata, s_rresp);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if (m_rready !== 1'b0 || s_rvalid !== 1'b0 || s_arready !== 1'b1) begin
                failed++;
                $display("FAIL rst_mid_after%0d: got m_rready=%b s_rvalid=%b s_arready=%b want 0 0 1",
                         i, m_rready, s_rvalid, s_arready);
            end
        end
        m_rvalid = 1'b0;
        run_fetch(32'h8000_00C4, 1'b1, -1, -1, 1'b0, 0, "rst_mid_refetch");
        run_fetch(32'h8000_0004, 1'b1, -1, -1, 1'b0, 0, "rst_cleared_valid");
    endtask

    initial begin
        rst       = 1'b0;
        fence_i   = 1'b0;
        s_arvalid = 1'b0;
        s_araddr  = 32'd0;
        s_rready  = 1'b0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = 32'd0;
        m_rresp   = 2'b00;
        m_rlast   = 1'b0;

        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_error();
        test_fence_refill();
        test_fence_idle();
        test_fence_hit();
        test_back_to_back();
        test_reset_mid_refill();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
